irq_sequencer: RTL

- CPU-side consumer of the interrupt controller outputs (IRQ, isr_addr); produces IACK back to it.
- At an instruction boundary, takes a pending interrupt:
  - saves the return PC;
  - pulses IACK;
  - redirects fetch to the ISR address;
  - masks further interrupts until MRET.
- Owns the machine interrupt CSRs: mstatus.MIE/MPIE and mepc.
- Sits between intc_top and the core's PC/commit logic.

---
 rtl/irq_sequencer_pkg.sv | 11 +
 rtl/irq_sequencer_if.sv | 21 ++
 rtl/irq_sequencer_csr_file.sv | 71 +++++++
 rtl/irq_sequencer.sv | 55 +++++
 4 files changed

// File: rtl/irq_sequencer_pkg.sv
// irq_sequencer_pkg: shared FSM states, CSR addresses and field positions for the interrupt sequencer.
package irq_pkg;
  typedef enum logic [1:0] {IDLE, TAKE, IN_ISR} state_t;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_LAT_LAST = 12'h7C0;
  localparam logic [11:0] CSR_LAT_MAX  = 12'h7C1;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int LAT_W    = 16;
endpackage

// File: rtl/irq_sequencer_if.sv
// irq_sequencer_if: controller handshake, commit boundary and CSR bus between core and irq_sequencer.
interface irq_sequencer_if #(parameter int XLEN = 32, parameter int CSR_AW = 12);
  logic              IRQ;
  logic [XLEN-1:0]   isr_addr;
  logic              IACK;
  logic              instr_commit;
  logic [XLEN-1:0]   pc_next;
  logic              mret;
  logic              csr_we;
  logic [CSR_AW-1:0] csr_addr;
  logic [XLEN-1:0]   csr_wdata;
  logic [XLEN-1:0]   csr_rdata;
  logic              pc_redirect;
  logic [XLEN-1:0]   pc_target;
  logic              irq_stall;
  logic              in_isr;
  modport master (output IRQ, isr_addr, instr_commit, pc_next, mret, csr_we, csr_addr, csr_wdata,
                  input IACK, csr_rdata, pc_redirect, pc_target, irq_stall, in_isr);
  modport slave  (input IRQ, isr_addr, instr_commit, pc_next, mret, csr_we, csr_addr, csr_wdata,
                  output IACK, csr_rdata, pc_redirect, pc_target, irq_stall, in_isr);
endinterface

// File: rtl/irq_sequencer_csr_file.sv
// irq_csr_file: mstatus.MIE/MPIE and mepc storage with read mux; interrupt take drops same-cycle writes.
// Optional IRQ_LATENCY_CNT_EN adds the IRQ-to-take latency counter at 0x7C0/0x7C1.
module irq_csr_file
  import irq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_take,
  input  logic              i_mret,
  input  logic [XLEN-1:0]   i_pc_next,
  input  logic              i_we,
  input  logic [CSR_AW-1:0] i_addr,
  input  logic [XLEN-1:0]   i_wdata,
`ifdef IRQ_LATENCY_CNT_EN
  input  logic              i_idle_irq,
`endif
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_mie,
  output logic [XLEN-1:0]   o_mepc
);
  logic            r_mie, r_mpie;
  logic [XLEN-1:0] r_mepc, w_mstatus;
  logic            w_we, w_ms_we, w_mepc_we;
  assign w_we      = i_we && !i_take;
  assign w_ms_we   = w_we && i_addr == CSR_MSTATUS;
  assign w_mepc_we = w_we && i_addr == CSR_MEPC;
  assign o_mie     = r_mie;
  assign o_mepc    = r_mepc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
      r_mepc <= '0;
    end else begin
      r_mepc <= i_take ? (i_pc_next & ~XLEN'(3)) : w_mepc_we ? (i_wdata & ~XLEN'(3)) : r_mepc;
      r_mie  <= i_take ? 1'b0 : i_mret ? r_mpie : w_ms_we ? i_wdata[MIE_BIT] : r_mie;
      r_mpie <= i_take ? r_mie : i_mret ? 1'b1 : w_ms_we ? i_wdata[MPIE_BIT] : r_mpie;
    end
  end
`ifdef IRQ_LATENCY_CNT_EN
  logic [LAT_W-1:0] r_cnt, r_lat_last, r_lat_max;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_lat_last <= '0;
      r_lat_max  <= '0;
    end else begin
      r_cnt <= (i_take || !i_idle_irq) ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
      if (i_take) begin
        r_lat_last <= r_cnt;
        if (r_cnt > r_lat_max) r_lat_max <= r_cnt;
      end else if (w_we && i_addr == CSR_LAT_MAX) r_lat_max <= '0;
    end
  end
`endif
  always_comb begin
    w_mstatus           = '0;
    w_mstatus[MIE_BIT]  = r_mie;
    w_mstatus[MPIE_BIT] = r_mpie;
    o_rdata = i_addr == CSR_MSTATUS  ? w_mstatus :
              i_addr == CSR_MEPC     ? r_mepc :
`ifdef IRQ_LATENCY_CNT_EN
              i_addr == CSR_LAT_LAST ? XLEN'(r_lat_last) :
              i_addr == CSR_LAT_MAX  ? XLEN'(r_lat_max) :
`endif
              '0;
  end
endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: takes pending interrupts at commit boundaries, acknowledges, redirects fetch and handles MRET.
// Optional macro IRQ_LATENCY_CNT_EN enables the interrupt latency counter CSRs.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input logic clk,
  input logic rst,
  irq_sequencer_if.slave bus
);
  state_t          r_state, w_state_n;
  logic [XLEN-1:0] r_isr_q, w_mepc;
  logic            w_take, w_mret, w_mie;
  assign w_take = r_state == IDLE && bus.IRQ && w_mie && bus.instr_commit && !bus.mret;
  // Commit is stalled during TAKE, so an MRET there cannot retire.
  assign w_mret = rst && bus.instr_commit && bus.mret && r_state != TAKE;
  always_comb begin
    w_state_n = r_state;
    w_state_n = r_state == TAKE ? IN_ISR :
                w_take ? TAKE :
                (r_state == IN_ISR && w_mret) ? IDLE : r_state;
  end
  assign bus.IACK        = r_state == TAKE;
  assign bus.irq_stall   = r_state == TAKE;
  assign bus.in_isr      = r_state == IN_ISR;
  assign bus.pc_redirect = r_state == TAKE || w_mret;
  assign bus.pc_target   = r_state == TAKE ? r_isr_q : w_mret ? w_mepc : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_isr_q <= '0;
    end else begin
      r_state <= w_state_n;
      r_isr_q <= w_take ? bus.isr_addr : r_isr_q;
    end
  end
  irq_csr_file #(.XLEN(XLEN), .CSR_AW(CSR_AW)) u_csr (
    .clk        (clk),
    .rst        (rst),
    .i_take     (w_take),
    .i_mret     (w_mret),
    .i_pc_next  (bus.pc_next),
    .i_we       (bus.csr_we),
    .i_addr     (bus.csr_addr),
    .i_wdata    (bus.csr_wdata),
`ifdef IRQ_LATENCY_CNT_EN
    .i_idle_irq (r_state == IDLE && bus.IRQ),
`endif
    .o_rdata    (bus.csr_rdata),
    .o_mie      (w_mie),
    .o_mepc     (w_mepc)
  );
endmodule
